// File: rtl/fb_arb_pkg.sv
// Shared types for the framebuffer port arbiter.
// Widths, slot/state encodings and the posted-write entry.
package fb_arb_pkg;

  localparam int DATA_WIDTH = 24;
  localparam int ADDR_WIDTH = 10;

  typedef enum logic {
    NORMAL,
    FORCE_WR
  } arb_state_t;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_RD,
    SLOT_WR
  } slot_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Loader/scan-out bundle for the framebuffer arbiter.
// master drives requests, slave is the arbiter.
interface fb_port_arbiter_if;
  import fb_arb_pkg::*;

  logic                  i_wr_valid;
  logic [ADDR_WIDTH-1:0] i_wr_addr;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  o_wr_ready;
  logic                  o_wr_pending;
  logic                  i_rd_req;
  logic [ADDR_WIDTH-1:0] i_rd_addr;
  logic                  o_rd_gnt;
  logic                  o_rd_valid;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic [31:0]           o_rd_cnt;
  logic [31:0]           o_wr_cnt;
  logic [15:0]           o_force_cnt;

  modport slave (
    input  i_wr_valid, i_wr_addr, i_wr_data,
    input  i_rd_req, i_rd_addr,
    output o_wr_ready, o_wr_pending,
    output o_rd_gnt, o_rd_valid, o_rd_data,
    output o_rd_cnt, o_wr_cnt, o_force_cnt
  );

  modport master (
    output i_wr_valid, i_wr_addr, i_wr_data,
    output i_rd_req, i_rd_addr,
    input  o_wr_ready, o_wr_pending,
    input  o_rd_gnt, o_rd_valid, o_rd_data,
    input  o_rd_cnt, o_wr_cnt, o_force_cnt
  );

endinterface

// File: rtl/bram.sv
// Single-port framebuffer RAM, one access per cycle.
// Read data registered, one cycle latency, held between reads.
module bram #(
  parameter int DW = 24,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Write or registered read at the shared address
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/fb_wr_fifo.sv
// Posted-write FIFO for the framebuffer arbiter.
// Head is registered storage: no fall-through.
module fb_wr_fifo
  import fb_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wr_entry_t din,
  input  logic      pop,
  output wr_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  wr_entry_t   mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  assign head  = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // Entry storage
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  // Pointers; extra MSB separates full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Framebuffer BRAM arbiter: scan-out reads first, posted writes drain.
// FB_ARB_STATS_EN builds the read/write/forced-slot counters.
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int WR_FIFO_DEPTH = 4,
  parameter int MAX_WR_WAIT   = 8
) (
  input logic              clk,
  input logic              i_rst_n,
  fb_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_WR_WAIT + 1);

  arb_state_t            state;
  slot_t                 slot;
  logic [CW-1:0]         wait_cnt;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  we;
  logic                  re;
  logic                  rd_valid;
  wr_entry_t             din;
  wr_entry_t             head;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_q;

  assign din.addr = bus.i_wr_addr;
  assign din.data = bus.i_wr_data;
  assign push     = bus.i_wr_valid && !full;

  fb_wr_fifo #(
    .DEPTH (WR_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (i_rst_n),
    .push  (push),
    .din   (din),
    .pop   (we),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Slot choice in priority order; nothing is issued in reset
  always_comb begin
    slot = SLOT_IDLE;
    if (!i_rst_n)
      slot = SLOT_IDLE;
    else if (state == FORCE_WR && !empty)
      slot = SLOT_WR;
    else if (bus.i_rd_req)
      slot = SLOT_RD;
    else if (!empty)
      slot = SLOT_WR;
  end

  assign we       = (slot == SLOT_WR);
  assign re       = (slot == SLOT_RD);
  assign ram_addr = we ? head.addr : bus.i_rd_addr;

  bram #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH)
  ) u_bram (
    .clk   (clk),
    .we    (we),
    .re    (re),
    .addr  (ram_addr),
    .wdata (head.data),
    .rdata (ram_q)
  );

  // Starvation guard: count unserviced cycles, force a write slot
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= NORMAL;
      wait_cnt <= '0;
    end else begin
      if (empty || we)
        wait_cnt <= '0;
      else if (wait_cnt != CW'(MAX_WR_WAIT))
        wait_cnt <= wait_cnt + 1'b1;
      case (state)
        NORMAL:
          if (!empty && !we &&
              wait_cnt == CW'(MAX_WR_WAIT - 1))
            state <= FORCE_WR;
        FORCE_WR:
          if (we || empty) state <= NORMAL;
        default: state <= NORMAL;
      endcase
    end
  end

  // Read data valid the cycle after a grant
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) rd_valid <= 1'b0;
    else          rd_valid <= re;
  end

  assign bus.o_wr_ready   = i_rst_n && !full;
  assign bus.o_wr_pending = !empty;
  assign bus.o_rd_gnt     = re;
  assign bus.o_rd_valid   = rd_valid;
  assign bus.o_rd_data    = ram_q;

`ifdef FB_ARB_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic [15:0] force_cnt;

  // Saturating access statistics
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      force_cnt <= '0;
    end else begin
      if (re && rd_cnt != '1)
        rd_cnt <= rd_cnt + 1'b1;
      if (we && wr_cnt != '1)
        wr_cnt <= wr_cnt + 1'b1;
      if (we && state == FORCE_WR && force_cnt != '1)
        force_cnt <= force_cnt + 1'b1;
    end
  end

  assign bus.o_rd_cnt    = rd_cnt;
  assign bus.o_wr_cnt    = wr_cnt;
  assign bus.o_force_cnt = force_cnt;
`else
  assign bus.o_rd_cnt    = '0;
  assign bus.o_wr_cnt    = '0;
  assign bus.o_force_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter.
// Table of write/read-back vectors plus multi-cycle corner sequences.
module tb_fb_port_arbiter;

`ifdef FB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fb_port_arbiter_if bus ();

  fb_port_arbiter #(
    .WR_FIFO_DEPTH (4),
    .MAX_WR_WAIT   (8)
  ) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [9:0]  addr;
    logic [23:0] data;
  } vec_t;

  vec_t tbl [8];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [9:0] a, input logic [23:0] d);
    int n;
    n = 0;
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = a;
    bus.i_wr_data  = d;
    @(negedge clk);
    while (!bus.o_wr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("wr_accept_timeout", n, 0);
    step();
    bus.i_wr_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (bus.o_wr_pending && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("drain_timeout", n, 0);
  endtask

  task automatic rd(input logic [9:0] a, input logic [23:0] exp,
                    input string nm);
    bus.i_rd_req  = 1'b1;
    bus.i_rd_addr = a;
    @(negedge clk);
    chk({nm, "_gnt"}, bus.o_rd_gnt, 1);
    step();
    bus.i_rd_req = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, bus.o_rd_valid, 1);
    chk({nm, "_data"}, bus.o_rd_data, exp);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cnt;
    int n;
    logic [9:0]  a4 [5];
    logic [23:0] d4 [5];

    tbl[0] = '{10'h000, 24'h000001};
    tbl[1] = '{10'h3FF, 24'hFFFFFF};
    tbl[2] = '{10'h020, 24'h000000};
    tbl[3] = '{10'h100, 24'h0A0B0C};
    tbl[4] = '{10'h101, 24'h5A5A5A};
    tbl[5] = '{10'h102, 24'hC3C3C3};
    tbl[6] = '{10'h1AA, 24'h800000};
    tbl[7] = '{10'h055, 24'h00FF00};

    a4[0] = 10'h060; d4[0] = 24'h000001;
    a4[1] = 10'h061; d4[1] = 24'h000002;
    a4[2] = 10'h062; d4[2] = 24'h000003;
    a4[3] = 10'h060; d4[3] = 24'h000004;
    a4[4] = 10'h063; d4[4] = 24'h000005;

    rst_n          = 1'b0;
    bus.i_wr_valid = 1'b0;
    bus.i_wr_addr  = '0;
    bus.i_wr_data  = '0;
    bus.i_rd_req   = 1'b0;
    bus.i_rd_addr  = '0;

    // reset, then idle
    step();
    step();
    chk("rst_ready", bus.o_wr_ready, 0);
    chk("rst_rd_valid", bus.o_rd_valid, 0);
    chk("rst_pending", bus.o_wr_pending, 0);
    chk("rst_rd_cnt", bus.o_rd_cnt, 0);
    chk("rst_force_cnt", bus.o_force_cnt, 0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", bus.o_wr_ready, 1);
    chk("idle_pending", bus.o_wr_pending, 0);
    chk("idle_rd_valid", bus.o_rd_valid, 0);

    // single write then read back
    push_wr(10'h010, 24'hA5A5A5);
    chk("t2_pending", bus.o_wr_pending, 1);
    drain();
    rd(10'h010, 24'hA5A5A5, "t2");

    // table: post all, drain, read each back
    for (int i = 0; i < 8; i++)
      push_wr(tbl[i].addr, tbl[i].data);
    drain();
    for (int i = 0; i < 8; i++)
      rd(tbl[i].addr, tbl[i].data, $sformatf("tbl%0d", i));
    chk("wr_cnt", bus.o_wr_cnt, STATS ? 32'd9 : 32'd0);
    chk("rd_cnt", bus.o_rd_cnt, STATS ? 32'd9 : 32'd0);

    // starvation guard under continuous reads
    bus.i_rd_req  = 1'b1;
    bus.i_rd_addr = 10'h3FF;
    step();
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = 10'h050;
    bus.i_wr_data  = 24'h123456;
    @(negedge clk);
    chk("t3_push_gnt", bus.o_rd_gnt, 1);
    step();
    bus.i_wr_valid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.o_rd_gnt) cnt++;
      else break;
    end
    chk("t3_wait_cycles", cnt, 8);
    chk("t3_force_pending", bus.o_wr_pending, 1);
    step();
    chk("t3_drained", bus.o_wr_pending, 0);
    chk("t3_force_cnt", bus.o_force_cnt, STATS ? 32'd1 : 32'd0);
    bus.i_rd_req = 1'b0;
    rd(10'h050, 24'h123456, "t3_rb");

    // FIFO overflow back-pressure under continuous reads
    bus.i_rd_req  = 1'b1;
    bus.i_rd_addr = 10'h3FF;
    for (int i = 0; i < 5; i++) begin
      bus.i_wr_valid = 1'b1;
      bus.i_wr_addr  = a4[i];
      bus.i_wr_data  = d4[i];
      @(negedge clk);
      if (i == 4) chk("t4_ready_full", bus.o_wr_ready, 0);
      else        chk($sformatf("t4_ready%0d", i), bus.o_wr_ready, 1);
      n = 0;
      while (!bus.o_wr_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) chk("t4_accept_timeout", n, 0);
      step();
    end
    bus.i_wr_valid = 1'b0;
    drain();
    bus.i_rd_req = 1'b0;
    rd(10'h060, 24'h000004, "t4_a60");
    rd(10'h061, 24'h000002, "t4_a61");
    rd(10'h062, 24'h000003, "t4_a62");
    rd(10'h063, 24'h000005, "t4_a63");

    // no RAW forwarding: same-cycle read sees old data
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = 10'h020;
    bus.i_wr_data  = 24'h111111;
    bus.i_rd_req   = 1'b1;
    bus.i_rd_addr  = 10'h020;
    @(negedge clk);
    chk("t5_gnt", bus.o_rd_gnt, 1);
    step();
    bus.i_wr_valid = 1'b0;
    bus.i_rd_req   = 1'b0;
    @(negedge clk);
    chk("t5_valid", bus.o_rd_valid, 1);
    chk("t5_old_data", bus.o_rd_data, 24'h000000);
    step();
    drain();
    rd(10'h020, 24'h111111, "t5_new");

    // reset with posted writes and a read in flight
    bus.i_rd_req  = 1'b1;
    bus.i_rd_addr = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      bus.i_wr_valid = 1'b1;
      bus.i_wr_addr  = tbl[3+i].addr;
      bus.i_wr_data  = 24'hDEAD00 + 24'(i);
      step();
    end
    bus.i_wr_valid = 1'b0;
    @(negedge clk);
    chk("t6_pre_pending", bus.o_wr_pending, 1);
    chk("t6_pre_gnt", bus.o_rd_gnt, 1);
    rst_n = 1'b0;
    step();
    chk("t6_rd_valid", bus.o_rd_valid, 0);
    chk("t6_pending", bus.o_wr_pending, 0);
    chk("t6_ready_rst", bus.o_wr_ready, 0);
    rst_n        = 1'b1;
    bus.i_rd_req = 1'b0;
    step();
    chk("t6_ready", bus.o_wr_ready, 1);
    chk("t6_force_cnt", bus.o_force_cnt, 0);
    for (int i = 0; i < 3; i++)
      rd(tbl[3+i].addr, tbl[3+i].data, $sformatf("t6_old%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
